// File: rtl/config_pkg.sv
// Shared definitions for the serial configuration loader: frame geometry
// defaults, FSM state encoding and a saturating counter helper.
package config_pkg;

    localparam int ADR_W_DEF  = 2;
    localparam int DAT_W_DEF  = 16;
    localparam int FRAME_BITS = ADR_W_DEF + DAT_W_DEF;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for an asynchronous input, followed by a registered
// rise/fall detector; level is delay-matched to the edge pulses.
module sync_edge #(
    parameter int STAGES  = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain  <= {STAGES{RST_VAL}};
            last_q <= RST_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            last_q <= chain[STAGES-1];
            rise   <= chain[STAGES-1] & ~last_q;
            fall   <= ~chain[STAGES-1] & last_q;
        end
    end

    assign level = last_q;

endmodule

// File: rtl/config_loader.sv
// Serial frame receiver: synchronizes a chip-select/clock/data link, shifts in
// an address+data frame and issues a single register-bank write per valid frame.
module config_loader
    import config_pkg::*;
#(
    parameter int ADR_W       = ADR_W_DEF,
    parameter int DAT_W       = DAT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ser_cs_n_i,
    input  logic             ser_clk_i,
    input  logic             ser_dat_i,
    input  logic             err_clr_i,
    output logic             reg_wr_o,
    output logic [ADR_W-1:0] reg_adr_o,
    output logic [DAT_W-1:0] reg_dat_o,
    output logic             busy_o,
    output logic             frame_err_o
);

    localparam int FBITS  = ADR_W + DAT_W;
    localparam int SETTLE = SYNC_STAGES + 2;
    localparam int SET_W  = $clog2(SETTLE + 1);

    logic cs_level, cs_rise, cs_fall;
    logic clk_level, clk_rise, clk_fall;
    logic dat_level, dat_rise, dat_fall;
    logic unused_sync;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk   (clk_i),
        .rst   (rst_i),
        .d     (ser_cs_n_i),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_clk_sync (
        .clk   (clk_i),
        .rst   (rst_i),
        .d     (ser_clk_i),
        .level (clk_level),
        .rise  (clk_rise),
        .fall  (clk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_dat_sync (
        .clk   (clk_i),
        .rst   (rst_i),
        .d     (ser_dat_i),
        .level (dat_level),
        .rise  (dat_rise),
        .fall  (dat_fall)
    );

    assign unused_sync = ^{clk_level, clk_fall, dat_rise, dat_fall};

    // After reset the select pipeline still holds its reset value, so a
    // low select would look like a fresh falling edge; only accept frame
    // starts once the pipeline has settled and select has been seen high.
    logic [SET_W-1:0] settle_cnt;
    logic             armed;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            settle_cnt <= '0;
            armed      <= 1'b0;
        end else begin
            if (settle_cnt != SET_W'(SETTLE)) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
            if (settle_cnt == SET_W'(SETTLE) && cs_level) begin
                armed <= 1'b1;
            end
        end
    end

    state_t            state, state_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [FBITS-1:0]  shift_reg;
    logic              frame_full;
    logic              start_frame, shift_en, err_set, commit;

    assign frame_full = (bit_cnt == CNT_W'(FBITS));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cs_fall && armed) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_next = frame_full ? COMMIT : IDLE;
                end
            end
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A select rise wins over a coincident bit-clock rise: that bit is dropped.
    always_comb begin
        busy_o      = (state == SHIFT);
        start_frame = (state == IDLE) && cs_fall && armed;
        shift_en    = (state == SHIFT) && clk_rise && !cs_rise;
        err_set     = (state == SHIFT) && cs_rise && !frame_full;
        commit      = (state == COMMIT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_cnt     <= '0;
            shift_reg   <= '0;
            reg_wr_o    <= 1'b0;
            reg_adr_o   <= '0;
            reg_dat_o   <= '0;
            frame_err_o <= 1'b0;
        end else begin
            reg_wr_o <= commit;
            if (start_frame) begin
                bit_cnt   <= '0;
                shift_reg <= '0;
            end else if (shift_en) begin
                bit_cnt   <= sat_inc(bit_cnt);
                shift_reg <= {shift_reg[FBITS-2:0], dat_level};
            end
            if (commit) begin
                reg_adr_o <= shift_reg[FBITS-1 -: ADR_W];
                reg_dat_o <= shift_reg[DAT_W-1:0];
            end
            if (err_set) begin
                frame_err_o <= 1'b1;
            end else if (err_clr_i) begin
                frame_err_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: directed frames plus random frames
// compared against a frame-level reference model of expected writes and errors.
module tb_config_loader;

    localparam int FB    = 18;
    localparam int PH    = 6;
    localparam int LATCY = 4;

    logic        clk;
    logic        rst;
    logic        ser_cs_n;
    logic        ser_clk;
    logic        ser_dat;
    logic        err_clr;
    logic        reg_wr;
    logic [1:0]  reg_adr;
    logic [15:0] reg_dat;
    logic        busy;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cs_hi_cyc = 0;
    int last_wr_cyc = 0;
    int high_cycles = 0;
    int pulses = 0;
    logic wr_prev = 1'b0;

    logic [FB-1:0] obs_q[$];
    logic [FB-1:0] exp_q[$];
    logic [FB-1:0] last_commit = '0;
    bit            exp_err = 1'b0;

    config_loader dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ser_cs_n_i  (ser_cs_n),
        .ser_clk_i   (ser_clk),
        .ser_dat_i   (ser_dat),
        .err_clr_i   (err_clr),
        .reg_wr_o    (reg_wr),
        .reg_adr_o   (reg_adr),
        .reg_dat_o   (reg_dat),
        .busy_o      (busy),
        .frame_err_o (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write pulse as it appears on the register-bank port.
    always @(negedge clk) begin
        if (reg_wr) begin
            high_cycles++;
            if (!wr_prev) begin
                pulses++;
                obs_q.push_back({reg_adr, reg_dat});
                last_wr_cyc = cyc;
            end
        end
        wr_prev = reg_wr;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // mode 0: normal end, 1: select and bit clock rise together,
    // 2: reset mid-frame then keep clocking with select low, 3: clear races the error
    task automatic applyStimulus(input logic [23:0] bits, input int n, input int mode);
        @(negedge clk);
        ser_clk  = 1'b0;
        ser_cs_n = 1'b0;
        waitCycles(PH);
        for (int i = n - 1; i >= 0; i--) begin
            ser_dat = bits[i];
            waitCycles(PH);
            ser_clk = 1'b1;
            waitCycles(PH);
            ser_clk = 1'b0;
        end
        case (mode)
            1: begin
                ser_dat = 1'($urandom);
                waitCycles(PH);
                ser_clk   = 1'b1;
                ser_cs_n  = 1'b1;
                cs_hi_cyc = cyc + 1;
                waitCycles(PH);
                ser_clk = 1'b0;
            end
            2: begin
                waitCycles(PH);
                rst = 1'b1;
                waitCycles(2);
                rst = 1'b0;
                waitCycles(10);
                checkOutput("post_rst_busy", 32'(busy), 32'd0);
                for (int i = 0; i < FB; i++) begin
                    ser_dat = 1'($urandom);
                    waitCycles(PH);
                    ser_clk = 1'b1;
                    waitCycles(PH);
                    ser_clk = 1'b0;
                end
                checkOutput("cs_low_busy", 32'(busy), 32'd0);
                waitCycles(PH);
                ser_cs_n  = 1'b1;
                cs_hi_cyc = cyc + 1;
            end
            3: begin
                waitCycles(PH);
                ser_cs_n  = 1'b1;
                cs_hi_cyc = cyc + 1;
                waitCycles(3);
                err_clr = 1'b1;
                waitCycles(1);
                err_clr = 1'b0;
            end
            default: begin
                waitCycles(PH);
                ser_cs_n  = 1'b1;
                cs_hi_cyc = cyc + 1;
            end
        endcase
        waitCycles(16);
    endtask

    task automatic modelFrame(input logic [23:0] bits, input int n);
        if (n == FB) begin
            exp_q.push_back(bits[FB-1:0]);
            last_commit = bits[FB-1:0];
        end else begin
            exp_err = 1'b1;
        end
    endtask

    task automatic checkFrame(input string tag);
        checkOutput({tag, "_wr_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            checkOutput({tag, "_wr_frame"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        end
        obs_q.delete();
        exp_q.delete();
        checkOutput({tag, "_err"}, 32'(frame_err), 32'(exp_err));
        checkOutput({tag, "_hold_adr"}, 32'(reg_adr), 32'(last_commit[FB-1 -: 2]));
        checkOutput({tag, "_hold_dat"}, 32'(reg_dat), 32'(last_commit[15:0]));
        if (exp_err) begin
            err_clr = 1'b1;
            waitCycles(1);
            err_clr = 1'b0;
            waitCycles(1);
            exp_err = 1'b0;
            checkOutput({tag, "_err_clr"}, 32'(frame_err), 32'd0);
        end
    endtask

    initial begin
        logic [23:0] bits;
        int          n;
        int          mode;

        rst      = 1'b1;
        ser_cs_n = 1'b1;
        ser_clk  = 1'b0;
        ser_dat  = 1'b0;
        err_clr  = 1'b0;
        waitCycles(3);
        checkOutput("rst_wr", 32'(reg_wr), 32'd0);
        checkOutput("rst_adr", 32'(reg_adr), 32'd0);
        checkOutput("rst_dat", 32'(reg_dat), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        waitCycles(12);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        $display("[TB] single frame adr=2 dat=A5C3");
        bits = {6'd0, 2'd2, 16'hA5C3};
        applyStimulus(bits, FB, 0);
        checkOutput("latency", 32'(last_wr_cyc - cs_hi_cyc), 32'(LATCY));
        modelFrame(bits, FB);
        checkFrame("basic");

        $display("[TB] short and long frames");
        bits = 24'($urandom);
        applyStimulus(bits, 17, 0);
        modelFrame(bits, 17);
        checkFrame("len17");
        bits = 24'($urandom);
        applyStimulus(bits, 19, 0);
        modelFrame(bits, 19);
        checkFrame("len19");

        $display("[TB] error set racing the clear");
        bits = 24'($urandom);
        applyStimulus(bits, 10, 3);
        modelFrame(bits, 10);
        checkFrame("clr_race");

        $display("[TB] back-to-back frames");
        bits = {6'd0, 2'd0, 16'hFFFF};
        applyStimulus(bits, FB, 0);
        modelFrame(bits, FB);
        bits = {6'd0, 2'd3, 16'h1234};
        applyStimulus(bits, FB, 0);
        modelFrame(bits, FB);
        checkFrame("b2b");

        $display("[TB] reset mid-frame with select held low");
        bits = 24'($urandom);
        applyStimulus(bits, 9, 2);
        last_commit = '0;
        exp_err     = 1'b0;
        checkFrame("rst_abort");
        bits = {6'd0, 2'd1, 16'h0001};
        applyStimulus(bits, FB, 0);
        modelFrame(bits, FB);
        checkFrame("after_rst");

        $display("[TB] select and clock rising together");
        bits = 24'($urandom);
        applyStimulus(bits, FB, 1);
        checkOutput("tie_latency", 32'(last_wr_cyc - cs_hi_cyc), 32'(LATCY));
        modelFrame(bits, FB);
        checkFrame("tie18");
        bits = 24'($urandom);
        applyStimulus(bits, 17, 1);
        modelFrame(bits, 17);
        checkFrame("tie17");

        $display("[TB] random frames");
        for (int k = 0; k < 16; k++) begin
            bits = 24'($urandom);
            n    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 23)) : FB;
            mode = int'($urandom_range(0, 1));
            applyStimulus(bits, n, mode);
            modelFrame(bits, n);
            checkFrame("rand");
        end

        checkOutput("wr_width", 32'(high_cycles), 32'(pulses));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
